// File: rtl/ot_pack_buffer_if.sv
// Byte-in / packed-word-out bus of the output packing buffer.
// The quantizer and the FIFO reader drive the master side.
// The packing buffer sits on the slave side.
interface ot_pack_buffer_if #(
   parameter int DATA_W = 64
);
   logic              q_valid;
   logic [7:0]        q_out;
   logic              q_last;
   logic              valid_out;
   logic [DATA_W-1:0] out64bits;
   logic              fifo_read;
   logic              fifo_empty_n;
   logic [DATA_W-1:0] fifo_data_out;
   logic              fifo_error;

   modport master (
      output q_valid, q_out, q_last, fifo_read,
      input  valid_out, out64bits, fifo_empty_n, fifo_data_out, fifo_error
   );

   modport slave (
      input  q_valid, q_out, q_last, fifo_read,
      output valid_out, out64bits, fifo_empty_n, fifo_data_out, fifo_error
   );
endinterface

// File: rtl/ot_pack_buffer.sv
// Output-stage packing buffer.
// Bytes from the quantizer are packed MSB-lane first into DATA_W-bit words.
// A word is emitted on the eighth byte or on a column-last byte, and the
// missing lanes are zero-padded. Each emitted word is pulsed once on
// valid_out and also queued in a show-ahead FIFO. A dropped FIFO write sets
// the sticky fifo_error flag.
module ot_pack_buffer #(
   parameter int DATA_W     = 64,
   parameter int FIFO_DEPTH = 16
) (
   input logic             clk,
   input logic             reset,
   ot_pack_buffer_if.slave bus
);

   localparam int NBYTES = DATA_W / 8;
   localparam int BCNT_W = $clog2(NBYTES);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);

   localparam logic [BCNT_W-1:0] LAST_LANE = BCNT_W'(NBYTES - 1);
   localparam logic [PTR_W:0]    CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0]    CNT_ONE   = (PTR_W + 1)'(1);

   // Lane 0 sits in the top byte, so the first byte received is the most
   // significant byte of the word.
   function automatic logic [DATA_W-1:0] lane_insert(
      input logic [DATA_W-1:0] word,
      input logic [BCNT_W-1:0] lane,
      input logic [7:0]        b
   );
      logic [DATA_W-1:0] r;
      int                base;
      r    = word;
      base = DATA_W - 8 - 8 * int'(lane);
      r[base +: 8] = b;
      return r;
   endfunction

   // Returns the next occupancy value. Only one of push or pop changes it.
   function automatic logic [PTR_W:0] count_next(
      input logic [PTR_W:0] cnt,
      input logic           push,
      input logic           pop
   );
      logic [PTR_W:0] r;
      r = cnt;
      if (push && !pop) begin
         r = cnt + CNT_ONE;
      end else if (pop && !push) begin
         r = cnt - CNT_ONE;
      end
      return r;
   endfunction

   // Packer state (_p0) and the registered emit stage (_p1)
   logic [BCNT_W-1:0] bcnt_p0;
   logic [DATA_W-1:0] stage_p0;
   logic [DATA_W-1:0] lane_word_p0;
   logic              emit_p0;
   logic              vld_p1;
   logic [DATA_W-1:0] word_p1;

   // FIFO state
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count;
   logic              error_q;
   logic              fifo_full;
   logic              fifo_nonempty;
   logic              rd_ok;
   logic              wr_ok;
   logic              wr_drop;

   // ---- stage p0: insert the incoming byte into its lane; decide on emit
   // Merge the incoming byte into the staging word and detect word completion
   always_comb begin
      lane_word_p0 = lane_insert(stage_p0, bcnt_p0, bus.q_out);
      emit_p0      = bus.q_valid && ((bcnt_p0 == LAST_LANE) || bus.q_last);
   end

   // ---- stage p1: registered word pulse; staging clears when a word is emitted
   // Advance the byte counter, hold through input gaps, emit completed words
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bcnt_p0  <= '0;
         stage_p0 <= '0;
         vld_p1   <= 1'b0;
         word_p1  <= '0;
      end else begin
         vld_p1 <= emit_p0;
         if (bus.q_valid) begin
            if (emit_p0) begin
               word_p1  <= lane_word_p0;
               bcnt_p0  <= '0;
               stage_p0 <= '0;
            end else begin
               stage_p0 <= lane_word_p0;
               bcnt_p0  <= bcnt_p0 + 1'b1;
            end
         end
      end
   end

   assign bus.valid_out = vld_p1;
   assign bus.out64bits = word_p1;

   // ---- FIFO: written from the p1 pulse, read show-ahead
   // A read is honoured only when there is data. When the FIFO is full, a
   // write is accepted only if a read frees a slot in the same cycle.
   always_comb begin
      fifo_full     = (count == CNT_FULL);
      fifo_nonempty = (count != '0);
      rd_ok         = bus.fifo_read && fifo_nonempty;
      wr_ok         = vld_p1 && (!fifo_full || rd_ok);
      wr_drop       = vld_p1 && fifo_full && !rd_ok;
   end

   // Pointer, occupancy and sticky overflow bookkeeping
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         error_q <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count_next(count, wr_ok, rd_ok);
         if (wr_drop) begin
            error_q <= 1'b1;
         end
      end
   end

   // Storage array holds data only; its validity is tracked by count
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= word_p1;
      end
   end

   assign bus.fifo_empty_n  = fifo_nonempty;
   assign bus.fifo_data_out = fifo_nonempty ? mem[rd_ptr] : '0;
   assign bus.fifo_error    = error_q;

endmodule

// File: tb/tb_ot_pack_buffer.sv
// Testbench for ot_pack_buffer: directed phases plus a randomized phase.
// A queue-based reference model predicts every output cycle by cycle.
module tb_ot_pack_buffer;

   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic reset;

   ot_pack_buffer_if #(.DATA_W(64)) bus ();

   ot_pack_buffer #(.DATA_W(64), .FIFO_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // reference model state
   logic [7:0]  cur[$];
   logic [63:0] fq[$];
   bit          exp_vld;
   logic [63:0] exp_word;
   bit          exp_err;

   // observed pulses
   logic [63:0] obs[$];
   int          obs_cyc[$];

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, o, e);
      end
   endtask

   task automatic step(input bit v, input logic [7:0] b, input bit l, input bit rd);
      bit          full;
      bit          popped;
      bit          nv;
      logic [63:0] nw;
      bus.q_valid   = v;
      bus.q_out     = b;
      bus.q_last    = l;
      bus.fifo_read = rd;
      @(posedge clk);
      cyc++;
      full   = (fq.size() == DEPTH);
      popped = rd && (fq.size() > 0);
      if (popped) void'(fq.pop_front());
      if (exp_vld) begin
         if (full && !popped) exp_err = 1'b1;
         else fq.push_back(exp_word);
      end
      nv = 1'b0;
      nw = 64'd0;
      if (v) begin
         cur.push_back(b);
         if (cur.size() == 8 || l) begin
            foreach (cur[i]) nw = nw | (64'(cur[i]) << (8 * (7 - i)));
            nv = 1'b1;
            cur.delete();
         end
      end
      exp_vld = nv;
      if (nv) exp_word = nw;
      #1;
      chk("valid_out", 64'(bus.valid_out), 64'(exp_vld));
      if (exp_vld) chk("out64bits", bus.out64bits, exp_word);
      if (bus.valid_out) begin
         obs.push_back(bus.out64bits);
         obs_cyc.push_back(cyc);
      end
      chk("fifo_empty_n", 64'(bus.fifo_empty_n), 64'(fq.size() > 0));
      chk("fifo_data_out", bus.fifo_data_out, (fq.size() > 0) ? fq[0] : 64'd0);
      chk("fifo_error", 64'(bus.fifo_error), 64'(exp_err));
   endtask

   task automatic idle(input int n, input bit rd);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, rd);
   endtask

   task automatic send_rand(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
   endtask

   // asserted between clock edges; outputs must clear without waiting for an edge
   task automatic do_reset();
      bus.q_valid   = 1'b0;
      bus.q_last    = 1'b0;
      bus.fifo_read = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("rst_valid_out", 64'(bus.valid_out), 64'd0);
      chk("rst_out64bits", bus.out64bits, 64'd0);
      chk("rst_fifo_empty_n", 64'(bus.fifo_empty_n), 64'd0);
      chk("rst_fifo_data_out", bus.fifo_data_out, 64'd0);
      chk("rst_fifo_error", 64'(bus.fifo_error), 64'd0);
      cur.delete();
      fq.delete();
      exp_vld = 1'b0;
      exp_err = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      logic [7:0]  b49;
      logic [63:0] tmp;
      reset         = 1'b1;
      bus.q_valid   = 1'b0;
      bus.q_out     = 8'h00;
      bus.q_last    = 1'b0;
      bus.fifo_read = 1'b0;
      exp_vld       = 1'b0;
      exp_word      = 64'd0;
      exp_err       = 1'b0;
      do_reset();

      // spaced packing: 0x01..0x28, one byte every 4 cycles
      obs.delete();
      for (int k = 1; k <= 40; k++) begin
         step(1'b1, 8'(k), 1'b0, 1'b0);
         idle(3, 1'b0);
      end
      chk("spaced_count", 64'(obs.size()), 64'd5);
      chk("spaced_w1", obs[0], 64'h0102030405060708);
      chk("spaced_w5", obs[4], 64'h2122232425262728);
      idle(6, 1'b1);

      // column flush, then a full word confirms the counter restarted
      obs.delete();
      for (int k = 0; k < 5; k++) step(1'b1, 8'(8'hA0 + k), (k == 4), 1'b0);
      for (int k = 0; k < 8; k++) step(1'b1, 8'(8'h10 + k), 1'b0, 1'b0);
      idle(1, 1'b0);
      chk("flush_count", 64'(obs.size()), 64'd2);
      chk("flush_word", obs[0], 64'hA0A1A2A3A4000000);
      chk("flush_next", obs[1], 64'h1011121314151617);
      idle(3, 1'b1);

      // continuous stream of 49 bytes, idle, then 7 more
      obs.delete();
      obs_cyc.delete();
      b49 = 8'h00;
      for (int k = 1; k <= 49; k++) begin
         tmp = 64'($urandom);
         if (k == 49) b49 = tmp[7:0];
         step(1'b1, tmp[7:0], 1'b0, 1'b0);
      end
      idle(20, 1'b0);
      chk("stream_count", 64'(obs.size()), 64'd6);
      for (int i = 1; i < 6; i++) chk("stream_spacing", 64'(obs_cyc[i] - obs_cyc[i-1]), 64'd8);
      send_rand(7);
      chk("stream_count7", 64'(obs.size()), 64'd7);
      tmp = obs[6];
      chk("stream_w7_byte49", 64'(tmp[63:56]), 64'(b49));
      idle(8, 1'b1);

      // FIFO fill and drain with one extra read while empty
      obs.delete();
      send_rand(24);
      idle(2, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("fill_drain_order", bus.fifo_data_out, obs[i]);
         step(1'b0, 8'h00, 1'b0, 1'b1);
      end
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("drain_empty", 64'(bus.fifo_empty_n), 64'd0);
      chk("drain_no_error", 64'(bus.fifo_error), 64'd0);

      // overflow: DEPTH+1 words, no reads
      obs.delete();
      send_rand(8 * (DEPTH + 1));
      idle(2, 1'b0);
      chk("ovf_error_set", 64'(bus.fifo_error), 64'd1);
      for (int i = 0; i < DEPTH; i++) begin
         chk("ovf_drain", bus.fifo_data_out, obs[i]);
         step(1'b0, 8'h00, 1'b0, 1'b1);
      end
      chk("ovf_drained_empty", 64'(bus.fifo_empty_n), 64'd0);
      chk("ovf_error_sticky", 64'(bus.fifo_error), 64'd1);

      // full FIFO with simultaneous read and write: no error
      do_reset();
      obs.delete();
      send_rand(8 * (DEPTH + 1));
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("full_rw_no_error", 64'(bus.fifo_error), 64'd0);
      chk("full_rw_nonempty", 64'(bus.fifo_empty_n), 64'd1);
      for (int i = 1; i <= DEPTH; i++) begin
         chk("full_rw_drain", bus.fifo_data_out, obs[i]);
         step(1'b0, 8'h00, 1'b0, 1'b1);
      end
      chk("full_rw_empty", 64'(bus.fifo_empty_n), 64'd0);

      // reset with 3 partial bytes and 2 words queued
      send_rand(16);
      send_rand(3);
      do_reset();
      obs.delete();
      for (int k = 0; k < 8; k++) step(1'b1, 8'(8'h31 + k), 1'b0, 1'b0);
      chk("post_reset_count", 64'(obs.size()), 64'd1);
      chk("post_reset_word", obs[0], 64'h3132333435363738);
      idle(2, 1'b1);

      // randomized traffic with gaps, column flushes and reads
      for (int i = 0; i < 800; i++) begin
         step(($urandom_range(0, 3) != 0), 8'($urandom),
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
